// File: rtl/fetch_queue_stage_pkg.sv
// Shared types for the queued instruction fetch stage:
// queue entries {pc, inst} and outstanding-read tags {pc, epoch}.
package fetch_queue_stage_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        epoch;
  } fetch_tag_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO (DEPTH a power of two) with push, pop, one-cycle flush.
// Ports: push/din, pop/dout, flush, full, empty, count (0..DEPTH).
module fetch_fifo
  import fetch_queue_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Extra pointer MSB tells full from empty.
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// Multi-outstanding instruction fetch with a QUEUE_DEPTH instruction queue
// and epoch-tagged redirect. Memory port: mem_start/ready/addr, mem_data(_valid).
// ID port: if_valid/reg_pc/inst/inst_id, if_stall_flg; redirect: branch_hazard/
// branch_target. Optional macro FETCH_BYPASS_EN: same-cycle response bypass.
module fetch_queue_stage
  import fetch_queue_stage_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_start,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mem_data_valid,
  output logic        if_valid,
  output logic [31:0] if_reg_pc,
  output logic [31:0] if_inst,
  output logic [63:0] if_inst_id,
  input  logic        if_stall_flg,
  input  logic        branch_hazard,
  input  logic [31:0] branch_target
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] MO = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0]   QD = (CW + 1)'(QUEUE_DEPTH);

  fetch_entry_t q_din, q_dout, head;
  fetch_tag_t   t_din, t_dout;

  logic          q_push, q_pop, q_full, q_empty;
  logic          t_push, t_full, t_empty;
  logic [CW-1:0] q_count, t_count;
  logic [CW:0]   inflight;

  logic [31:0] fpc;
  logic        epoch;
  logic [63:0] inst_id;
  logic        rsp_live;
  logic        bypass;
  logic        deliver;

  // Credits use registered occupancy only; a pop frees room next cycle.
  assign inflight  = {1'b0, q_count} + {1'b0, t_count};
  assign mem_start = rst_n && !branch_hazard &&
                     !t_full && !q_full &&
                     (t_count < MO) && (inflight < QD);
  assign mem_addr  = fpc;

  assign t_push = mem_start && mem_ready;
  assign t_din  = '{pc: fpc, epoch: epoch};

  // A response without a tag (e.g. after reset) is ignored.
  assign rsp_live = mem_data_valid && !t_empty &&
                    (t_dout.epoch == epoch) && !branch_hazard;

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_live && q_empty;
`else
  assign bypass = 1'b0;
`endif

  assign head = bypass ? '{pc: t_dout.pc, inst: mem_data} : q_dout;

  assign if_valid   = (!q_empty || bypass) && !branch_hazard;
  assign if_reg_pc  = (q_empty && !bypass) ? '0 : head.pc;
  assign if_inst    = (q_empty && !bypass) ? '0 : head.inst;
  assign if_inst_id = inst_id;

  assign deliver = if_valid && !if_stall_flg;
  assign q_din   = '{pc: t_dout.pc, inst: mem_data};
  assign q_push  = rsp_live && !(bypass && deliver);
  assign q_pop   = deliver && !bypass;

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .din   (q_din),
    .pop   (q_pop),
    .flush (branch_hazard),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Tags survive a redirect so stale responses are consumed and dropped.
  fetch_fifo #(
    .WIDTH ($bits(fetch_tag_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_tags (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (t_push),
    .din   (t_din),
    .pop   (mem_data_valid),
    .flush (1'b0),
    .dout  (t_dout),
    .full  (t_full),
    .empty (t_empty),
    .count (t_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc     <= RESET_VECTOR;
      epoch   <= 1'b0;
      inst_id <= '0;
    end else if (branch_hazard) begin
      fpc     <= branch_target;
      epoch   <= ~epoch;
    end else begin
      if (t_push)  fpc     <= fpc + 32'd4;
      if (deliver) inst_id <= inst_id + 64'd1;
    end
  end

endmodule
